// File: rtl/commit_trace_checker.sv
// Retirement-stream checker: verifies PC continuity, counts commits and mispredictions,
// stops on EBREAK and buffers retired {pc, instr} pairs for a valid/ready trace reader.
module commit_trace_checker #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          DEPTH      = 16,
    parameter int          AW         = 4,
    parameter logic [31:0] HALT_INSTR = 32'h0010_0073
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        commit_i,
    input  logic [31:0] commit_pc_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] commit_pre_pc_i,
    input  logic [31:0] commit_pred_pc_i,
    output logic        trace_valid_o,
    input  logic        trace_ready_i,
    output logic [31:0] trace_pc_o,
    output logic [31:0] trace_instr_o,
    output logic [31:0] commit_cnt_o,
    output logic [31:0] mispred_cnt_o,
    output logic [15:0] drop_cnt_o,
    output logic        pc_error_o,
    output logic [31:0] err_pc_o,
    output logic [31:0] err_expected_o,
    output logic        halted_o
);

    localparam logic [0:0]  ST_RUN  = 1'b0;
    localparam logic [0:0]  ST_HALT = 1'b1;
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [0:0]    state_q, state_d;
    logic [31:0]   expected_pc_q, expected_pc_d;
    logic [31:0]   commit_cnt_q, commit_cnt_d;
    logic [31:0]   mispred_cnt_q, mispred_cnt_d;
    logic [15:0]   drop_cnt_q, drop_cnt_d;
    logic          pc_error_q, pc_error_d;
    logic [31:0]   err_pc_q, err_pc_d;
    logic [31:0]   err_expected_q, err_expected_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [63:0]   mem_q [DEPTH];

    logic accept;
    logic pop;
    logic push;
    logic full;

    assign accept = commit_i && (state_q == ST_RUN);
    assign full   = (count_q == FULL_COUNT);
    assign pop    = (count_q != '0) && trace_ready_i;
    // A full FIFO still takes the new entry when the head leaves on the same edge.
    assign push   = accept && (!full || pop);

    always_comb begin
        state_d        = state_q;
        expected_pc_d  = expected_pc_q;
        commit_cnt_d   = commit_cnt_q;
        mispred_cnt_d  = mispred_cnt_q;
        drop_cnt_d     = drop_cnt_q;
        pc_error_d     = pc_error_q;
        err_pc_d       = err_pc_q;
        err_expected_d = err_expected_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q + (AW+1)'(push) - (AW+1)'(pop);

        if (accept) begin
            commit_cnt_d  = commit_cnt_q + 32'd1;
            expected_pc_d = commit_pre_pc_i;
            if (commit_pred_pc_i != commit_pre_pc_i) begin
                mispred_cnt_d = mispred_cnt_q + 32'd1;
            end
            if ((commit_pc_i != expected_pc_q) && !pc_error_q) begin
                pc_error_d     = 1'b1;
                err_pc_d       = commit_pc_i;
                err_expected_d = expected_pc_q;
            end
            if (!push && (drop_cnt_q != 16'hFFFF)) begin
                drop_cnt_d = drop_cnt_q + 16'd1;
            end
            if (instr_i == HALT_INSTR) begin
                state_d = ST_HALT;
            end
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= ST_RUN;
            expected_pc_q  <= RESET_PC;
            commit_cnt_q   <= '0;
            mispred_cnt_q  <= '0;
            drop_cnt_q     <= '0;
            pc_error_q     <= 1'b0;
            err_pc_q       <= '0;
            err_expected_q <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
        end else begin
            state_q        <= state_d;
            expected_pc_q  <= expected_pc_d;
            commit_cnt_q   <= commit_cnt_d;
            mispred_cnt_q  <= mispred_cnt_d;
            drop_cnt_q     <= drop_cnt_d;
            pc_error_q     <= pc_error_d;
            err_pc_q       <= err_pc_d;
            err_expected_q <= err_expected_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {commit_pc_i, instr_i};
        end
    end

    assign trace_valid_o  = (count_q != '0);
    assign trace_pc_o     = trace_valid_o ? mem_q[rd_ptr_q][63:32] : 32'h0;
    assign trace_instr_o  = trace_valid_o ? mem_q[rd_ptr_q][31:0]  : 32'h0;
    assign commit_cnt_o   = commit_cnt_q;
    assign mispred_cnt_o  = mispred_cnt_q;
    assign drop_cnt_o     = drop_cnt_q;
    assign pc_error_o     = pc_error_q;
    assign err_pc_o       = err_pc_q;
    assign err_expected_o = err_expected_q;
    assign halted_o       = (state_q == ST_HALT);

endmodule
